// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment digit scanner.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } scan_state_e;

    // Active-high glyphs, bit 0 = segment a; entry n is hex digit n.
    localparam logic [15:0][SEG_W-1:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_mux_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment glyph decode.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = GLYPHS[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// Seven-segment scanner: one digit per refClk edge, blank guard before each digit,
// tear-free commit at frame wrap. Macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                sysClk,
    input  logic                rst,
    input  logic                refClk,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    output logic                ack,
    output logic                pending,
    output logic [DIGITS-1:0]   an,
    output logic [SEG_W-1:0]    seg,
    output logic                dpOut
);

    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = 8;

    scan_state_e       state, state_d;
    logic [2:0]        sync;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [VAL_W-1:0]  shadow_val, disp_val, disp_val_d;
    logic [DIGITS-1:0] shadow_dp, disp_dp, disp_dp_d;
    logic              tick_c, wrap_c, commit_c, pending_d, lit_c, blank_c;
    logic [3:0]        nibble_c;
    logic [SEG_W-1:0]  glyph_c, seg_d;
    logic [DIGITS-1:0] an_d;
    logic              dp_d;

    // Either refClk edge is one step.
    assign tick_c = sync[1] ^ sync[2];

    always_ff @(posedge sysClk) begin
        if (rst) state <= OFF;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        wrap_c  = 1'b0;
        unique case (state)
            OFF: begin
                if (tick_c) begin
                    state_d = GUARD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    wrap_c  = 1'b1;
                end
            end
            GUARD, ON: begin
                if (tick_c) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        idx_d  = '0;
                        wrap_c = 1'b1;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end else if (state == GUARD) begin
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) state_d = ON;
                    else                                 cnt_d   = cnt + CNT_W'(1);
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Commit sees the pre-load shadow; a coincident load stays pending.
    assign commit_c   = wrap_c & pending;
    assign pending_d  = load | (pending & ~commit_c);
    assign disp_val_d = commit_c ? shadow_val : disp_val;
    assign disp_dp_d  = commit_c ? shadow_dp  : disp_dp;
    assign nibble_c   = 4'(disp_val_d >> {idx_d, 2'b00});

    hex_to_seg u_dec (
        .nibble (nibble_c),
        .seg_c  (glyph_c)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_c;

    always_comb begin
        msd_c = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (disp_val_d[4*i +: 4] != 4'h0) msd_c = IDX_W'(i);
        end
    end

    assign blank_c = (idx_d > msd_c);
`else
    assign blank_c = 1'b0;
`endif

    assign lit_c = (state_d == ON);
    assign an_d  = lit_c ? (DIGITS'(1) << idx_d) : '0;
    assign seg_d = (lit_c && !blank_c) ? glyph_c : '0;
    assign dp_d  = lit_c & disp_dp_d[idx_d];

    always_ff @(posedge sysClk) begin
        if (rst) begin
            sync       <= '0;
            idx        <= '0;
            cnt        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            ack        <= 1'b0;
            an         <= {DIGITS{ACTIVE_LOW}};
            seg        <= {SEG_W{ACTIVE_LOW}};
            dpOut      <= ACTIVE_LOW;
        end else begin
            sync       <= {sync[1:0], refClk};
            idx        <= idx_d;
            cnt        <= cnt_d;
            disp_val   <= disp_val_d;
            disp_dp    <= disp_dp_d;
            pending    <= pending_d;
            ack        <= commit_c;
            an         <= an_d  ^ {DIGITS{ACTIVE_LOW}};
            seg        <= seg_d ^ {SEG_W{ACTIVE_LOW}};
            dpOut      <= dp_d  ^ ACTIVE_LOW;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux against an event-level scan/commit model.
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int G      = 16;

    logic        sysClk = 1'b0;
    logic        rst, refClk, load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        ack, pending, dpOut;
    logic [3:0]  an;
    logic [6:0]  seg;

    seg_scan_mux #(.DIGITS(4), .GUARD_CYCLES(16), .ACTIVE_LOW(1'b1)) dut (
        .sysClk(sysClk), .rst(rst), .refClk(refClk), .load(load), .value(value), .dp(dp),
        .ack(ack), .pending(pending), .an(an), .seg(seg), .dpOut(dpOut)
    );

    always #5 sysClk = ~sysClk;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int tick_due [$];
    int nticks = 0, last_tick = 0, last_toggle = 0, ref_period = 0;
    logic [15:0] m_shadow = '0, m_disp = '0;
    logic [3:0]  m_shadow_dp = '0, m_disp_dp = '0;
    bit          m_pending = 1'b0, m_ack = 1'b0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    function automatic int msd(input logic [15:0] v);
        msd = 0;
        for (int i = 1; i < DIGITS; i++) if (v[4*i +: 4] != 4'h0) msd = i;
    endfunction
`endif

    // Model: a refClk toggle becomes a step 3 clocks later; every DIGITS-th step starts a frame.
    task automatic model_edge();
        bit tk;
        if (rst) begin
            tick_due.delete();
            nticks = 0; last_tick = 0;
            m_shadow = '0; m_shadow_dp = '0; m_disp = '0; m_disp_dp = '0;
            m_pending = 1'b0; m_ack = 1'b0;
            return;
        end
        tk = (tick_due.size() > 0) && (tick_due[0] == cyc);
        m_ack = 1'b0;
        if (tk) begin
            void'(tick_due.pop_front());
            nticks++;
            last_tick = cyc;
            if (((nticks - 1) % DIGITS == 0) && m_pending) begin
                m_disp = m_shadow; m_disp_dp = m_shadow_dp;
                m_pending = 1'b0; m_ack = 1'b1;
            end
        end
        if (load) begin
            m_shadow = value; m_shadow_dp = dp; m_pending = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge sysClk);
        cyc++;
        model_edge();
        #1;
        if (ref_period != 0 && cyc - last_toggle >= ref_period) begin
            refClk = ~refClk;
            tick_due.push_back(cyc + 3);
            last_toggle = cyc;
        end
    endtask

    task automatic run_and_check(input int n);
        bit lit, blank;
        int dig;
        logic [3:0] nib, e_an;
        logic [6:0] e_seg;
        logic e_dp;
        for (int k = 0; k < n; k++) begin
            step();
            lit   = (nticks > 0) && (cyc - last_tick >= G);
            dig   = (nticks > 0) ? (nticks - 1) % DIGITS : 0;
            nib   = 4'(m_disp >> (4 * dig));
            blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            blank = (dig > msd(m_disp));
`endif
            e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
            e_seg = (lit && !blank) ? ~GLYPH[nib] : 7'h7F;
            e_dp  = lit ? ~m_disp_dp[dig] : 1'b1;
            total++;
            if ({an, seg, dpOut, ack, pending} !== {e_an, e_seg, e_dp, m_ack, m_pending})
                $display("FAIL cycle %0d an/seg/dp/ack/pend actual=%h/%h/%b/%b/%b required=%h/%h/%b/%b/%b",
                         cyc, an, seg, dpOut, ack, pending, e_an, e_seg, e_dp, m_ack, m_pending);
            else passed++;
        end
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value = v; dp = d;
        run_and_check(1);
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] pat, input int bound, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            run_and_check(1);
            if (an === pat) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) $display("FAIL %s timeout waiting an=%h actual an=%h", tag, pat, an);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; refClk = 1'b0; load = 1'b0; value = '0; dp = '0; ref_period = 0;
        run_and_check(3);
        rst = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            run_and_check(1);
            total++;
            if (an !== 4'hF || seg !== 7'h7F || pending !== 1'b0)
                $display("FAIL idle an/seg/pend actual=%h/%h/%b required=f/7f/0", an, seg, pending);
            else passed++;
        end
    endtask

    task automatic test_scan_order();
        logic [6:0] want [4];
        bit got [4];
        bit seen_ack = 1'b0;
        want = '{7'h19, 7'h30, 7'h24, 7'h79};
        got  = '{1'b0, 1'b0, 1'b0, 1'b0};
        drive_load(16'h1234, 4'($urandom));
        ref_period = 200; last_toggle = cyc;
        for (int k = 0; k < 1900; k++) begin
            run_and_check(1);
            if (ack === 1'b1) seen_ack = 1'b1;
            if (seen_ack) for (int d = 0; d < 4; d++) begin
                if (an === ~(4'b0001 << d) && !got[d]) begin
                    got[d] = 1'b1;
                    total++;
                    if (seg !== want[d]) $display("FAIL scan digit%0d seg actual=%h required=%h", d, seg, want[d]);
                    else passed++;
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            total++;
            if (!got[d]) $display("FAIL scan digit%0d never lit actual=0 required=1", d);
            else passed++;
        end
    endtask

    task automatic test_tear_free();
        bit ok = 1'b0;
        wait_an(4'b1011, 2000, "tear_wait_d2");
        drive_load(16'hABCD, 4'($urandom));
        for (int k = 0; k < 1500; k++) begin
            run_and_check(1);
            if (ack === 1'b1) begin ok = 1'b1; break; end
            if (an === 4'b0111) begin
                total++;
                if (seg !== 7'h79) $display("FAIL tear old_d3 seg actual=%h required=79", seg);
                else passed++;
            end
        end
        total++;
        if (!ok) $display("FAIL tear ack timeout actual=0 required=1"); else passed++;
        wait_an(4'b0111, 1500, "tear_wait_new_d3");
        total++;
        if (seg !== 7'h08) $display("FAIL tear new_d3 seg actual=%h required=08", seg); else passed++;
    endtask

    task automatic test_double_load();
        int acks = 0;
        wait_an(4'b1101, 2000, "dbl_wait_d1");
        drive_load(16'h1111, 4'($urandom));
        run_and_check(30);
        drive_load(16'h2222, 4'($urandom));
        for (int k = 0; k < 1000; k++) begin
            run_and_check(1);
            if (ack === 1'b1) acks++;
        end
        total++;
        if (acks != 1) $display("FAIL dbl ack count actual=%0d required=1", acks); else passed++;
        wait_an(4'b0111, 1000, "dbl_wait_d3");
        total++;
        if (seg !== 7'h24) $display("FAIL dbl d3 seg actual=%h required=24", seg); else passed++;
    endtask

    task automatic test_load_at_commit();
        bit ok = 1'b0;
        wait_an(4'b1101, 2000, "sim_wait_d1");
        drive_load(16'h5555, 4'($urandom));
        for (int k = 0; k < 2000; k++) begin
            if (tick_due.size() > 0 && tick_due[0] == cyc + 1 && nticks % DIGITS == 0) begin
                ok = 1'b1; break;
            end
            run_and_check(1);
        end
        total++;
        if (!ok) $display("FAIL sim wrap not found actual=0 required=1"); else passed++;
        drive_load(16'h6666, 4'($urandom));
        total++;
        if (ack !== 1'b1 || pending !== 1'b1)
            $display("FAIL sim commit ack/pend actual=%b/%b required=1/1", ack, pending);
        else passed++;
        wait_an(4'b1110, 500, "sim_wait_d0");
        total++;
        if (seg !== 7'h12) $display("FAIL sim d0 five seg actual=%h required=12", seg); else passed++;
        ok = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            run_and_check(1);
            if (ack === 1'b1) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || pending !== 1'b0)
            $display("FAIL sim second ack/pend actual=%b/%b required=1/0", ok, pending);
        else passed++;
        wait_an(4'b1110, 500, "sim_wait_d0b");
        total++;
        if (seg !== 7'h02) $display("FAIL sim d0 six seg actual=%h required=02", seg); else passed++;
    endtask

    task automatic test_guard_retick();
        ref_period = 8;
        run_and_check(20);
        for (int k = 0; k < 300; k++) begin
            run_and_check(1);
            total++;
            if (an !== 4'hF) $display("FAIL retick an actual=%h required=f", an); else passed++;
        end
        ref_period = 60;
        run_and_check(400);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_and_check($urandom_range(0, 300));
            drive_load(16'($urandom), 4'($urandom));
        end
        run_and_check(600);
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        drive_load(16'($urandom) | 16'h0001, 4'($urandom));
        run_and_check(5);
        rst = 1'b1; refClk = 1'b0; ref_period = 0;
        run_and_check(2);
        rst = 1'b0;
        total++;
        if (pending !== 1'b0 || ack !== 1'b0 || an !== 4'hF)
            $display("FAIL rstmid pend/ack/an actual=%b/%b/%h required=0/0/f", pending, ack, an);
        else passed++;
        ref_period = 60; last_toggle = cyc;
        for (int k = 0; k < 600; k++) begin
            run_and_check(1);
            if (ack === 1'b1) acks++;
        end
        total++;
        if (acks != 0) $display("FAIL rstmid ack count actual=%0d required=0", acks); else passed++;
        wait_an(4'b1110, 300, "rstmid_wait_d0");
        total++;
        if (seg !== 7'h40) $display("FAIL rstmid d0 seg actual=%h required=40", seg); else passed++;
    endtask

`ifdef SEG_LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        logic [15:0] vals [2];
        logic [6:0]  want [2][4];
        vals = '{16'h0042, 16'h0000};
        want = '{'{7'h24, 7'h19, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
        for (int c = 0; c < 2; c++) begin
            bit ok = 1'b0;
            drive_load(vals[c], 4'($urandom));
            for (int k = 0; k < 600; k++) begin
                run_and_check(1);
                if (ack === 1'b1) begin ok = 1'b1; break; end
            end
            total++;
            if (!ok) $display("FAIL lzb ack timeout case%0d actual=0 required=1", c); else passed++;
            for (int d = 0; d < 4; d++) begin
                wait_an(~(4'b0001 << d), 400, "lzb_wait");
                total++;
                if (seg !== want[c][d])
                    $display("FAIL lzb case%0d digit%0d seg actual=%h required=%h", c, d, seg, want[c][d]);
                else passed++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_double_load();
        test_load_at_commit();
        test_guard_retick();
        test_random();
        test_reset_mid();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed seven-segment digit scanner that consumes the divided refresh clock produced by the display clock divider. It edge-detects `refClk` in the `sysClk` domain, steps one digit per `refClk` edge, inserts an anti-ghosting blank interval before each digit, and drives anodes, segments and decimal point. It also provides tear-free updates: a value loaded mid-frame is committed only at the frame boundary and acknowledged with a pulse.

## Interface
- `DIGITS`, 4: number of digits scanned, range 2–8.
- `GUARD_CYCLES`, 16: `sysClk` cycles with all anodes off before each digit turns on; range 1–255; must be smaller than the `refClk` half-period.
- `ACTIVE_LOW`, 1: 1 means anodes and segments are driven low to light; 0 means driven high.
- `sysClk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `refClk`  in  1  divided refresh clock (a level that toggles); each edge is one digit step.
- `load`  in  1  one-cycle request to capture `value`/`dp`.
- `value`  in  4*DIGITS  hex nibbles; nibble 0 is the rightmost digit.
- `dp`  in  DIGITS  decimal-point enables, one per digit.
- `ack`  out  1  one-cycle pulse when a loaded value becomes visible.
- `pending`  out  1  high from `load` until the matching `ack`.
- `an`  out  DIGITS  anode enables, one-hot when lit.
- `seg`  out  7  segments a–g; bit 0 is a.
- `dpOut`  out  1  decimal point for the lit digit.

## Operation
- **Edge detect.** A 2-flop synchronizer feeds a third flop. `tick` = XOR of the last two stages. Both rising and falling edges produce a tick.
- **Registers.** `shadow` (value + dp) is written on `load`. `disp` holds what is shown. `idx` ranges 0..DIGITS-1.
- **FSM states:**
  - `OFF`, entered on reset: all off; waits for the first tick.
  - `GUARD`: all anodes off; counter runs 0..GUARD_CYCLES-1.
  - `ON`: the selected anode is on; `seg`/`dpOut` come from `disp` nibble `idx`.
- **Transitions:**
  - `OFF`→`GUARD` on tick; `idx`=0.
  - `GUARD`→`ON` when the counter reaches GUARD_CYCLES-1.
  - `ON`→`GUARD` on tick; `idx` advances, wrapping DIGITS-1→0.
  - A tick during `GUARD` advances `idx` and restarts the counter.
- **Commit.** When `idx` wraps to 0 and `pending`=1:
  - `disp` <= `shadow`;
  - `pending` clears;
  - `ack` pulses in the same cycle.
- **Load corner cases:**
  - `load` while `pending`=1 overwrites `shadow`; only one `ack` follows, for the latest value.
  - `load` in the same cycle as a commit: the commit uses the pre-load `shadow`; the new value stays pending until the next wrap.
- **Decode.** Nibbles 0–F map to standard hex glyphs. Polarity inversion is applied at the output registers when ACTIVE_LOW=1.
- **Reset mid-operation.** All state is cleared immediately: `disp`=0, `shadow`=0, FSM to `OFF`. No `ack` is issued for a discarded pending load.

## Timing
- **Reset values:**
  - `an`, `seg` and `dpOut` are all inactive (all ones when ACTIVE_LOW=1).
  - `ack`=0, `pending`=0, `idx`=0.
- **Tick latency.** `tick` asserts 3 `sysClk` cycles after a `refClk` edge.
- **Output latency.** Outputs are registered. The anode turns on exactly GUARD_CYCLES+1 cycles after `tick`, and goes off 1 cycle after `tick`.
- **Pending/ack timing.** `pending` rises the cycle after `load`. `ack` is exactly 1 cycle wide. New segments appear on the first digit-0 ON following `ack`.
- **Commit bound.** Worst case from `load` to commit is DIGITS ticks plus 3 cycles.

## Configuration
- **`SEG_LEADING_ZERO_BLANK_EN` defined:** digits above the most-significant nonzero nibble of `disp` are blanked (segments off, anode still cycles). `dpOut` still follows `dp`. Digit 0 is never blanked.
- **Undefined:** every digit shows its nibble, including leading zeros.

## Structure
- **Package `seg_pkg`:**
  - FSM state enum: `OFF`, `GUARD`, `ON`;
  - 16-entry active-high glyph constant table;
  - `MAX_DIGITS`=8.
- **Sub-module `hex_to_seg`:** combinational nibble→7-bit active-high decode using the package table. Instantiated once, on the muxed nibble.

## Test plan
- **Reset/idle:** reset, no `refClk` edges for 1000 cycles → `an`=4'b1111, `seg`=7'h7F, `pending`=0.
- **Scan order:** load 16'h1234 and toggle `refClk` every 200 cycles → after commit, digits 0..3 light in order with segs for 4,3,2,1. All anodes are off for 16 cycles after each tick.
- **Tear-free:** load 16'hABCD while `idx`=2 → `ack` fires at the wrap to `idx`=0, not earlier. Digit 3 still shows the old nibble on its pass before the wrap.
- **Double load:** load 16'h1111, then 16'h2222 before the wrap → exactly one `ack`; display is 2222.
- **Simultaneous load and commit:** load 16'h5555 pending, then load 16'h6666 in the commit cycle → 5555 is shown with `ack`. `pending` stays 1, and 6666 commits with `ack` at the next wrap.
- **Leading-zero blanking:** with `SEG_LEADING_ZERO_BLANK_EN`, load 16'h0042 → digits 3 and 2 have segments off; digits 1 and 0 show 4 and 2. With 16'h0000, only digit 0 shows 0.
